program_loader: RTL and testbench

- Writer side of the CPU program store. Receives a byte stream from the host, unpacks two 4-bit opcodes per byte and writes them sequentially into a writable program RAM, starting at address 0. The CPU fetch path later reads the same RAM.
- Holds the CPU (busyOut) while loading.
- Validates the length header and an XOR checksum, and reports done or error.

---
 rtl/program_loader.sv | 212 +++++++++++++++++++++
 tb/tb_program_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: unpacks a host byte stream into 4-bit opcodes and writes them to program RAM.
// Latency: 1 byte accepted per 3 cycles (DATA, WR_LO, WR_HI); a write appears the cycle after its byte is accepted.
// Backpressure: byteReadyOut is held low during the two write cycles, so the host stalls until DATA/CHK comes round again.
//
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-high reset
//   loadStartIn        - start request, only honoured while idle
//   byteIn/byteValidIn - stream input; byteReadyOut accepts it (valid && ready on a rising edge)
//   wrEnOut/wrAddrOut/wrDataOut - program RAM write port (address/data hold while not writing)
//   busyOut            - high whenever a load is in progress (holds the CPU)
//   doneOut            - one-cycle pulse on a load that passed the checksum
//   errorOut           - sticky error (bad length or bad checksum), cleared by the next start
//   countOut           - opcodes written by the current/last load
module program_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  loadStartIn,
    input  logic [7:0]            byteIn,
    input  logic                  byteValidIn,
    output logic                  byteReadyOut,
    output logic                  wrEnOut,
    output logic [ADDR_WIDTH-1:0] wrAddrOut,
    output logic [3:0]            wrDataOut,
    output logic                  busyOut,
    output logic                  doneOut,
    output logic                  errorOut,
    output logic [ADDR_WIDTH:0]   countOut
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WR_LO,
        S_WR_HI,
        S_CHK,
        S_DONE
    } state_t;

    // Number of opcodes the program RAM can hold.
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    state_t                state_q;
    state_t                state_d;

    logic [7:0]            rem_q;      // opcodes still to be written
    logic [ADDR_WIDTH:0]   count_q;    // opcodes written so far; extra bit lets it reach CAPACITY
    logic [7:0]            acc_q;      // running XOR of every data byte, padding included
    logic [3:0]            hi_nib_q;   // high nibble of the current byte, written in WR_HI
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [3:0]            wr_data_q;
    logic                  err_q;

    logic                  len_ok;
    logic                  last_op;

    assign len_ok  = (byteIn != 8'd0) && ({24'd0, byteIn} <= CAPACITY);
    assign last_op = (rem_q == 8'd1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        byteReadyOut = 1'b0;
        wrEnOut      = 1'b0;
        busyOut      = 1'b1;
        doneOut      = 1'b0;

        case (state_q)
            S_IDLE: begin
                busyOut = 1'b0;
                if (loadStartIn) begin
                    state_d = S_LEN;
                end
            end

            S_LEN: begin
                byteReadyOut = 1'b1;
                if (byteValidIn) begin
                    state_d = len_ok ? S_DATA : S_IDLE;
                end
            end

            S_DATA: begin
                byteReadyOut = 1'b1;
                if (byteValidIn) begin
                    state_d = S_WR_LO;
                end
            end

            S_WR_LO: begin
                wrEnOut = 1'b1;
                state_d = last_op ? S_CHK : S_WR_HI;
            end

            S_WR_HI: begin
                wrEnOut = 1'b1;
                state_d = last_op ? S_CHK : S_DATA;
            end

            S_CHK: begin
                byteReadyOut = 1'b1;
                if (byteValidIn) begin
                    state_d = (byteIn == acc_q) ? S_DONE : S_IDLE;
                end
            end

            S_DONE: begin
                doneOut = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counters, checksum and the registered write port.
    // The write address/data are loaded one cycle ahead of the write
    // state so that they are stable for the whole write cycle and simply
    // hold afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q     <= 8'd0;
            count_q   <= '0;
            acc_q     <= 8'd0;
            hi_nib_q  <= 4'd0;
            wr_addr_q <= '0;
            wr_data_q <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Results of the previous load stay visible until a new one starts.
                    if (loadStartIn) begin
                        err_q   <= 1'b0;
                        count_q <= '0;
                        acc_q   <= 8'd0;
                        rem_q   <= 8'd0;
                    end
                end

                S_LEN: begin
                    if (byteValidIn) begin
                        if (len_ok) begin
                            rem_q <= byteIn;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (byteValidIn) begin
                        hi_nib_q  <= byteIn[7:4];
                        acc_q     <= acc_q ^ byteIn;
                        wr_data_q <= byteIn[3:0];
                        wr_addr_q <= count_q[ADDR_WIDTH-1:0];
                    end
                end

                S_WR_LO: begin
                    count_q <= count_q + (ADDR_WIDTH+1)'(1);
                    rem_q   <= rem_q - 8'd1;
                    // For an odd final opcode the high nibble is padding and
                    // is never presented on the write port.
                    if (!last_op) begin
                        wr_data_q <= hi_nib_q;
                        wr_addr_q <= count_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                    end
                end

                S_WR_HI: begin
                    count_q <= count_q + (ADDR_WIDTH+1)'(1);
                    rem_q   <= rem_q - 8'd1;
                end

                S_CHK: begin
                    if (byteValidIn && (byteIn != acc_q)) begin
                        err_q <= 1'b1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign wrAddrOut = wr_addr_q;
    assign wrDataOut = wr_data_q;
    assign errorOut  = err_q;
    assign countOut  = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader (ADDR_WIDTH=4, 16-opcode store).
// Stimulus: directed loads from the test plan followed by random loads with random stalls.
// A queue of expected RAM writes is built from the byte stream; a negedge monitor checks every write.
module tb_program_loader;

    localparam int AW  = 4;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          loadStartIn;
    logic [7:0]    byteIn;
    logic          byteValidIn;
    logic          byteReadyOut;
    logic          wrEnOut;
    logic [AW-1:0] wrAddrOut;
    logic [3:0]    wrDataOut;
    logic          busyOut;
    logic          doneOut;
    logic          errorOut;
    logic [AW:0]   countOut;

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .loadStartIn  (loadStartIn),
        .byteIn       (byteIn),
        .byteValidIn  (byteValidIn),
        .byteReadyOut (byteReadyOut),
        .wrEnOut      (wrEnOut),
        .wrAddrOut    (wrAddrOut),
        .wrDataOut    (wrDataOut),
        .busyOut      (busyOut),
        .doneOut      (doneOut),
        .errorOut     (errorOut),
        .countOut     (countOut)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [3:0] data;
    } wr_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    wr_t        exp_wr[$];
    wr_t        cur_wr;
    int         done_cnt = 0;
    bit         prev_done = 1'b0;
    int         last_count = 0;
    logic [7:0] pay[0:127];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_xor(input int nb);
        logic [7:0] r = 8'd0;
        for (int i = 0; i < nb; i++) r = r ^ pay[i];
        return r;
    endfunction

    function automatic logic [3:0] model_op(input int i);
        logic [7:0] b = pay[i / 2];
        return (i % 2 == 1) ? b[7:4] : b[3:0];
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            if (wrEnOut) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", {24'd0, 4'd0, wrAddrOut}, 32'hFFFF_FFFF);
                end else begin
                    cur_wr = exp_wr.pop_front();
                    check("wr_addr", 32'(wrAddrOut), 32'(cur_wr.addr));
                    check("wr_data", 32'(wrDataOut), 32'(cur_wr.data));
                end
                check("ready_low_while_writing", 32'(byteReadyOut), 32'd0);
            end
            check("done_err_exclusive", 32'(doneOut & errorOut), 32'd0);
            if (prev_done) check("idle_after_done", 32'(busyOut), 32'd0);
            if (doneOut) done_cnt++;
            prev_done = doneOut;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        byteIn      = b;
        byteValidIn = 1'b1;
        while (!byteReadyOut && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(byteReadyOut), 32'd1);
        @(posedge clk);
        #1;
        byteValidIn = 1'b0;
        byteIn      = 8'($urandom);
    endtask

    // Host idles between bytes; start requests sent meanwhile must be ignored.
    task automatic stall(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            loadStartIn = ($urandom_range(0, 3) == 0);
        end
        if (cycles > 0) begin
            @(posedge clk);
            #1;
        end
        loadStartIn = 1'b0;
    endtask

    task automatic start_load();
        @(negedge clk);
        loadStartIn = 1'b1;
        @(posedge clk);
        #1;
        loadStartIn = 1'b0;
        check("start_clears_err", 32'(errorOut), 32'd0);
        check("start_clears_count", 32'(countOut), 32'd0);
        check("busy_after_start", 32'(busyOut), 32'd1);
    endtask

    // stall_cyc < 0 selects random stalls of 0..3 cycles before each byte
    task automatic run_load(input int len, input logic [7:0] chk, input int stall_cyc);
        int         nb;
        bit         ok_len;
        bit         exp_done;
        int         exp_count;
        int         n;
        logic [7:0] x;
        nb        = (len + 1) / 2;
        ok_len    = (len >= 1) && (len <= CAP);
        x         = model_xor(nb);
        exp_done  = ok_len && (chk == x);
        exp_count = ok_len ? len : 0;
        if (ok_len)
            for (int i = 0; i < len; i++) exp_wr.push_back('{addr: 8'(i), data: model_op(i)});
        done_cnt = 0;

        // Valid data while idle is not a transfer.
        @(negedge clk);
        byteIn      = 8'($urandom);
        byteValidIn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_not_ready", 32'(byteReadyOut), 32'd0);
        check("idle_count_hold", 32'(countOut), 32'(last_count));
        byteValidIn = 1'b0;

        start_load();
        send_byte(8'(len));
        if (ok_len) begin
            for (int b = 0; b < nb; b++) begin
                stall(stall_cyc < 0 ? $urandom_range(0, 3) : stall_cyc);
                send_byte(pay[b]);
            end
            stall(stall_cyc < 0 ? $urandom_range(0, 3) : stall_cyc);
            send_byte(chk);
        end
        n = 0;
        while (busyOut && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("load_end_idle", 32'(busyOut), 32'd0);
        check("done_pulses", 32'(done_cnt), exp_done ? 32'd1 : 32'd0);
        check("error_flag", 32'(errorOut), exp_done ? 32'd0 : 32'd1);
        check("count", 32'(countOut), 32'(exp_count));
        check("writes_outstanding", 32'(exp_wr.size()), 32'd0);
        exp_wr.delete();
        last_count = exp_count;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        loadStartIn = 1'b0;
        byteValidIn = 1'b0;
        byteIn      = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(byteReadyOut), 32'd0);
        check("rst_busy",  32'(busyOut), 32'd0);
        check("rst_wren",  32'(wrEnOut), 32'd0);
        check("rst_addr",  32'(wrAddrOut), 32'd0);
        check("rst_data",  32'(wrDataOut), 32'd0);
        check("rst_done",  32'(doneOut), 32'd0);
        check("rst_err",   32'(errorOut), 32'd0);
        check("rst_count", 32'(countOut), 32'd0);
        reset = 1'b0;

        // Nominal odd length: writes 0,1,A; checksum 0x1A
        pay[0] = 8'h10; pay[1] = 8'h0A;
        check("model_xor_odd", 32'(model_xor(2)), 32'h1A);
        check("model_op_odd", 32'(model_op(2)), 32'hA);
        run_load(3, 8'h1A, 0);

        // Even length with 5-cycle host stalls: writes 1,A,B,2; checksum 0x8A
        pay[0] = 8'hA1; pay[1] = 8'h2B;
        check("model_xor_even", 32'(model_xor(2)), 32'h8A);
        check("model_op_even", 32'(model_op(3)), 32'h2);
        run_load(4, 8'h8A, 5);

        // Bad checksum: writes still happen, error sticks, next start clears it
        pay[0] = 8'h10;
        run_load(2, 8'h11, 1);
        check("err_sticky", 32'(errorOut), 32'd1);

        // Bad lengths, then the full store
        run_load(0, 8'h00, 0);
        run_load(17, 8'h00, 0);
        run_load(200, 8'h00, 0);
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        run_load(16, model_xor(8), -1);

        // Reset asserted during the WR_HI cycle of a 6-opcode load
        pay[0] = 8'h54; pay[1] = 8'h76; pay[2] = 8'h98;
        exp_wr.push_back('{addr: 8'd0, data: 4'h4});
        exp_wr.push_back('{addr: 8'd1, data: 4'h5});
        start_load();
        send_byte(8'd6);
        send_byte(8'h54);
        @(negedge clk);
        @(negedge clk);
        check("wr_hi_reached", 32'(wrEnOut && wrAddrOut == 1), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_wren",  32'(wrEnOut), 32'd0);
        check("async_rst_busy",  32'(busyOut), 32'd0);
        check("async_rst_addr",  32'(wrAddrOut), 32'd0);
        check("async_rst_data",  32'(wrDataOut), 32'd0);
        check("async_rst_count", 32'(countOut), 32'd0);
        check("async_rst_ready", 32'(byteReadyOut), 32'd0);
        check("async_rst_err",   32'(errorOut | doneOut), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_writes_seen", 32'(exp_wr.size()), 32'd0);
        exp_wr.delete();
        last_count = 0;
        run_load(6, model_xor(3), -1);

        // Random loads, some with bad lengths or corrupted checksums
        repeat (30) begin
            int         len;
            logic [7:0] c;
            len = $urandom_range(0, 20);
            for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
            c = model_xor((len + 1) / 2);
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            run_load(len, c, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
